image_stream_loader: RTL

IMAGE_STREAM_LOADER -- requirements
Module: image_stream_loader

---
 rtl/image_stream_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/image_stream_loader.sv
// image_stream_loader: loads a square frame of signed pixels from a
// valid/ready beat stream into a register frame buffer in row-major order.
// Optional build macro IMAGE_LOADER_CHECKSUM_EN adds a 16-bit additive
// checksum over the frame, followed by two checksum beats (low byte first).
module image_stream_loader #(
  parameter int top_bitwidth = 8,
  parameter int IMG_DIM      = 28
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic                                                  s_valid,
  input  logic signed [top_bitwidth-1:0]                        s_data,
  output logic                                                  s_ready,
  output logic signed [IMG_DIM-1:0][IMG_DIM-1:0][top_bitwidth-1:0] image,
  output logic                                                  busy,
  output logic                                                  frame_done,
  output logic                                                  image_valid,
  output logic                                                  chk_err
);

  localparam int IW = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IMG_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  state_t                                                   state_r;
  logic [IW-1:0]                                            row_r;
  logic [IW-1:0]                                            col_r;
  logic                                                     s_ready_r;
  logic                                                     busy_r;
  logic                                                     frame_done_r;
  logic                                                     image_valid_r;
  logic signed [IMG_DIM-1:0][IMG_DIM-1:0][top_bitwidth-1:0] image_r;

  logic accept_s;
  logic pix_wr_s;
  logic last_col_s;
  logic last_row_s;

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0]             acc_r;
  logic [7:0]              chk_lo_r;
  logic                    chk_cnt_r;
  logic                    chk_err_r;
  logic [top_bitwidth-1:0] pix_u_s;
`endif

  // Beat handshake and raster-position decode.
  always_comb begin
    accept_s   = s_valid && s_ready_r;
    pix_wr_s   = accept_s && (state_r == ST_LOAD);
    last_col_s = (col_r == LAST_IDX);
    last_row_s = (row_r == LAST_IDX);
  end

  // Frame buffer: one pixel written per accepted LOAD beat; untouched
  // entries keep the previous frame's contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      image_r <= '0;
    end else if (pix_wr_s) begin
      image_r[row_r][col_r] <= s_data;
    end
  end

`ifdef IMAGE_LOADER_CHECKSUM_EN
  // Pixel reinterpreted as unsigned before accumulation.
  always_comb begin
    pix_u_s = s_data;
  end

  // Checksum accumulator: unsigned sum of frame pixels, modulo 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && start) begin
      acc_r <= 16'h0000;
    end else if (pix_wr_s) begin
      acc_r <= acc_r + 16'(pix_u_s);
    end
  end
`endif

  // Control FSM: IDLE -> LOAD (-> CHK) -> IDLE, with all status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      row_r         <= '0;
      col_r         <= '0;
      s_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      image_valid_r <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      chk_lo_r      <= 8'h00;
      chk_cnt_r     <= 1'b0;
      chk_err_r     <= 1'b0;
`endif
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r       <= ST_LOAD;
            row_r         <= '0;
            col_r         <= '0;
            s_ready_r     <= 1'b1;
            busy_r        <= 1'b1;
            image_valid_r <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            chk_err_r     <= 1'b0;
            chk_cnt_r     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (last_col_s) begin
              col_r <= '0;
              if (last_row_s) begin
                row_r <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                state_r   <= ST_CHK;
                chk_cnt_r <= 1'b0;
`else
                state_r       <= ST_IDLE;
                s_ready_r     <= 1'b0;
                busy_r        <= 1'b0;
                image_valid_r <= 1'b1;
                frame_done_r  <= 1'b1;
`endif
              end else begin
                row_r <= row_r + 1'b1;
              end
            end else begin
              col_r <= col_r + 1'b1;
            end
          end
        end
        ST_CHK: begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
          if (accept_s) begin
            if (!chk_cnt_r) begin
              chk_lo_r  <= s_data[7:0];
              chk_cnt_r <= 1'b1;
            end else begin
              chk_cnt_r     <= 1'b0;
              chk_err_r     <= ({s_data[7:0], chk_lo_r} != acc_r);
              state_r       <= ST_IDLE;
              s_ready_r     <= 1'b0;
              busy_r        <= 1'b0;
              image_valid_r <= 1'b1;
              frame_done_r  <= 1'b1;
            end
          end
`else
          state_r   <= ST_IDLE;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
`endif
        end
        default: begin
          state_r   <= ST_IDLE;
          s_ready_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign image_valid = image_valid_r;
  assign image       = image_r;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign chk_err     = chk_err_r;
`else
  assign chk_err     = 1'b0;
`endif

endmodule
